// File: rtl/bayer_video_timing_ctrl.sv
// bayer_video_timing_ctrl
//   Master sequencer for the Bayer-to-RGB stage. It generates the raster
//   timing (h/v counters, active-video strobe, active-low vsync) and pops raw
//   Bayer pixels from an upstream first-word-fall-through FIFO in lock-step
//   with active video. The demosaic stage consumes o_vid_data directly.
//   A FIFO underflow does not stall the raster: the pixel is replaced by 0
//   and a sticky flag is raised until i_clr_err.
//
//   The hsync window is not generated here; downstream logic decodes it
//   from o_hdata.
//
//   Optional build macro BAYER_TPG_EN adds input i_tpg. When i_tpg is
//   sampled high at frame start, the frame carries an h^v test pattern
//   instead of FIFO data, the FIFO is not popped and underflow cannot set.
//
// Ports
//   i_clk         pixel clock, rising edge
//   i_rstn        asynchronous active-low reset
//   i_enable      run request (level)
//   i_fifo_valid  upstream FIFO holds a word
//   i_fifo_data   upstream Bayer pixel
//   i_clr_err     one-cycle pulse, clears o_underflow
//   i_tpg         test-pattern select (BAYER_TPG_EN builds only)
//   o_fifo_rd     FIFO pop (combinational)
//   o_vid_data    pixel to demosaic, aligned with o_vde
//   o_vsync       active-low vsync
//   o_vde         active-video strobe
//   o_hdata       registered h counter
//   o_vdata       registered v counter
//   o_underflow   sticky underflow flag
//   o_busy        sequencer not idle
//
// Counter widths are fixed at 11/10 bits, so HMAX <= 2048 and VMAX <= 1024.
module bayer_video_timing_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned HSIZE  = 1280,
  parameter int unsigned HMAX   = 1650,
  parameter int unsigned VSIZE  = 720,
  parameter int unsigned VFP    = 725,
  parameter int unsigned VSP    = 730,
  parameter int unsigned VMAX   = 750
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_enable,
  input  logic              i_fifo_valid,
  input  logic [DATA_W-1:0] i_fifo_data,
  input  logic              i_clr_err,
`ifdef BAYER_TPG_EN
  input  logic              i_tpg,
`endif
  output logic              o_fifo_rd,
  output logic [DATA_W-1:0] o_vid_data,
  output logic              o_vsync,
  output logic              o_vde,
  output logic [10:0]       o_hdata,
  output logic [9:0]        o_vdata,
  output logic              o_underflow,
  output logic              o_busy
);

  localparam logic [10:0] HSIZE_C = 11'(HSIZE);
  localparam logic [10:0] HLAST_C = 11'(HMAX - 1);
  localparam logic [9:0]  VSIZE_C = 10'(VSIZE);
  localparam logic [9:0]  VFP_C   = 10'(VFP);
  localparam logic [9:0]  VSP_C   = 10'(VSP);
  localparam logic [9:0]  VLAST_C = 10'(VMAX - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_RUN, ST_STOP} state_t;

  state_t      state;
  logic [10:0] h, h_nxt;
  logic [9:0]  v, v_nxt;
  logic        running, pix_act, frame_end, tpg_act, underflow_evt;
  logic [DATA_W-1:0] pix_nxt;

  logic [DATA_W-1:0] vid_data_p1;
  logic              vld_p1, vsync_p1, underflow_p1;
  logic [10:0]       hdata_p1;
  logic [9:0]        vdata_p1;

  assign running   = (state == ST_RUN) || (state == ST_STOP);
  assign pix_act   = running && (h < HSIZE_C) && (v < VSIZE_C);
  assign frame_end = (h == HLAST_C) && (v == VLAST_C);

`ifdef BAYER_TPG_EN
  // Pattern select is latched at raster origin; on the origin pixel itself
  // the live input is used so the very first pixel already follows it.
  logic tpg_frame;
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)                   tpg_frame <= 1'b0;
    else if (h == '0 && v == '0)   tpg_frame <= i_tpg;
  end
  assign tpg_act = (h == '0 && v == '0) ? i_tpg : tpg_frame;
`else
  assign tpg_act = 1'b0;
`endif

  assign o_fifo_rd     = pix_act && i_fifo_valid && !tpg_act;
  assign underflow_evt = pix_act && !i_fifo_valid && !tpg_act;

  always_comb begin
    h_nxt = h + 11'd1;
    v_nxt = v;
    if (h == HLAST_C) begin
      h_nxt = '0;
      v_nxt = (v == VLAST_C) ? '0 : v + 10'd1;
    end
  end

  always_comb begin
    pix_nxt = '0;
    if (o_fifo_rd) pix_nxt = i_fifo_data;
`ifdef BAYER_TPG_EN
    if (pix_act && tpg_act) pix_nxt = DATA_W'(h[7:0] ^ v[7:0]);
`endif
  end

  // Stage p0: sequencer state and raster counters
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= ST_IDLE;
      h     <= '0;
      v     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          h <= '0;
          v <= '0;
          if (i_enable) state <= ST_ARM;
        end
        ST_ARM: begin
          if (!i_enable)         state <= ST_IDLE;
          else if (i_fifo_valid) state <= ST_RUN;
        end
        ST_RUN: begin
          h <= h_nxt;
          v <= v_nxt;
          if (!i_enable) state <= ST_STOP;
        end
        ST_STOP: begin
          h <= h_nxt;
          v <= v_nxt;
          // Re-enable wins; otherwise drain to the end of the current frame.
          if (i_enable)       state <= ST_RUN;
          else if (frame_end) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Stage p1: registered video outputs, one cycle behind the counters
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      vid_data_p1  <= '0;
      vld_p1       <= 1'b0;
      vsync_p1     <= 1'b1;
      hdata_p1     <= '0;
      vdata_p1     <= '0;
      underflow_p1 <= 1'b0;
    end else begin
      vid_data_p1 <= pix_nxt;
      vld_p1      <= pix_act;
      vsync_p1    <= running ? !((v >= VFP_C) && (v < VSP_C)) : 1'b1;
      hdata_p1    <= h;
      vdata_p1    <= v;
      // A new underflow takes priority over a clear in the same cycle.
      if (underflow_evt)  underflow_p1 <= 1'b1;
      else if (i_clr_err) underflow_p1 <= 1'b0;
    end
  end

  assign o_vid_data  = vid_data_p1;
  assign o_vde       = vld_p1;
  assign o_vsync     = vsync_p1;
  assign o_hdata     = hdata_p1;
  assign o_vdata     = vdata_p1;
  assign o_underflow = underflow_p1;
  assign o_busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_bayer_video_timing_ctrl.sv
// Testbench for bayer_video_timing_ctrl, using a reduced raster so whole
// frames fit in a short run. A position-based model (linear pixel index
// within the frame plus a run mode) predicts every output each cycle;
// directed scenarios add literal expectations for frame statistics,
// latency, underflow, graceful stop and asynchronous reset.
module tb_bayer_video_timing_ctrl;
  localparam int HSIZE = 10;
  localparam int HMAX  = 14;
  localparam int VSIZE = 6;
  localparam int VFP   = 7;
  localparam int VSP   = 9;
  localparam int VMAX  = 10;
  localparam int FRAME = HMAX * VMAX;

  localparam int M_IDLE = 0, M_ARM = 1, M_RUN = 2, M_STOP = 3;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0, valid = 1'b0, clr = 1'b0, tpg = 1'b0;
  logic [7:0]  din = 8'd0;
  logic        fifo_rd, vsync, vde, underflow, busy;
  logic [7:0]  vid_data;
  logic [10:0] hdata;
  logic [9:0]  vdata;

  always #5 clk = ~clk;

  bayer_video_timing_ctrl #(
    .DATA_W(8), .HSIZE(HSIZE), .HMAX(HMAX), .VSIZE(VSIZE),
    .VFP(VFP), .VSP(VSP), .VMAX(VMAX)
  ) dut (
    .i_clk(clk), .i_rstn(rstn), .i_enable(en), .i_fifo_valid(valid),
    .i_fifo_data(din), .i_clr_err(clr),
`ifdef BAYER_TPG_EN
    .i_tpg(tpg),
`endif
    .o_fifo_rd(fifo_rd), .o_vid_data(vid_data), .o_vsync(vsync), .o_vde(vde),
    .o_hdata(hdata), .o_vdata(vdata), .o_underflow(underflow), .o_busy(busy)
  );

  int tests = 0, fails = 0;
  int rd_cnt = 0;

  // Model state
  int  m_mode = M_IDLE;
  int  m_pos  = 0;
  bit  m_tpg  = 1'b0;
  logic [10:0] e_hd = '0;
  logic [9:0]  e_vd = '0;
  logic        e_vde = 1'b0, e_vs = 1'b1, e_uf = 1'b0;
  logic [7:0]  e_data = '0;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit m_act();
    int h = m_pos % HMAX;
    int v = m_pos / HMAX;
    return (m_mode == M_RUN || m_mode == M_STOP) && h < HSIZE && v < VSIZE;
  endfunction

  function automatic bit m_tpg_eff();
    return (m_pos == 0) ? tpg : m_tpg;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_pos = 0; m_tpg = 1'b0;
    e_hd = '0; e_vd = '0; e_vde = 1'b0; e_vs = 1'b1; e_uf = 1'b0; e_data = '0;
  endtask

  // Advance the model across one rising edge using the inputs the DUT saw.
  task automatic model_update();
    int h, v;
    bit act, te, last;
    if (!rstn) begin
      model_reset();
      return;
    end
    h = m_pos % HMAX;
    v = m_pos / HMAX;
    act = m_act();
    te = m_tpg_eff();
    e_hd  = 11'(h);
    e_vd  = 10'(v);
    e_vde = act;
    e_vs  = !((m_mode == M_RUN || m_mode == M_STOP) && v >= VFP && v < VSP);
    if (act && te)         e_data = 8'(h ^ v);
    else if (act && valid) e_data = din;
    else                   e_data = 8'd0;
    if (act && !valid && !te) e_uf = 1'b1;
    else if (clr)             e_uf = 1'b0;
    if (m_pos == 0) m_tpg = tpg;
    last = (m_pos == FRAME - 1);
    case (m_mode)
      M_IDLE: begin
        m_pos = 0;
        if (en) m_mode = M_ARM;
      end
      M_ARM: begin
        if (!en)        m_mode = M_IDLE;
        else if (valid) m_mode = M_RUN;
      end
      M_RUN: begin
        m_pos = (m_pos + 1) % FRAME;
        if (!en) m_mode = M_STOP;
      end
      default: begin
        m_pos = (m_pos + 1) % FRAME;
        if (en)        m_mode = M_RUN;
        else if (last) begin m_mode = M_IDLE; m_pos = 0; end
      end
    endcase
  endtask

  // One clock: drive at the falling edge, check the combinational pop,
  // then check all registered outputs just after the rising edge.
  task automatic step(input bit e, input bit vl, input bit c, input logic [7:0] d);
    @(negedge clk);
    en = e; valid = vl; clr = c; din = d;
    #1;
    chk("fifo_rd", fifo_rd, m_act() && vl && !m_tpg_eff());
    if (fifo_rd) rd_cnt++;
    @(posedge clk);
    model_update();
    #1;
    chk("hdata", hdata, e_hd);
    chk("vdata", vdata, e_vd);
    chk("vde", vde, e_vde);
    chk("vsync", vsync, e_vs);
    chk("vid_data", vid_data, e_data);
    chk("underflow", underflow, e_uf);
    chk("busy", busy, m_mode != M_IDLE);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_vsync"}, vsync, 1);
    chk({tag, "_vde"}, vde, 0);
    chk({tag, "_hdata"}, hdata, 0);
    chk({tag, "_vdata"}, vdata, 0);
    chk({tag, "_vid_data"}, vid_data, 0);
    chk({tag, "_underflow"}, underflow, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_fifo_rd"}, fifo_rd, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, second, nvde, nvs, zeros, cnt;
    bit found;
    bit e_rand;

    // Reset state
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst");
    #1 rstn = 1'b1;

    // Continuous run with the FIFO always valid
    first = -1; second = -1; nvde = 0; nvs = 0;
    for (int k = 1; k <= 400; k++) begin
      step(1'b1, 1'b1, 1'b0, 8'(k * 7 + 3));
      if (vde && hdata == 0 && vdata == 0) begin
        if (first < 0) begin
          first = k;
          chk("first_vde_cycle", k, 3);
          chk("first_word", vid_data, 24);
        end else if (second < 0) begin
          second = k;
        end
      end
      if (first > 0 && k < first + FRAME) begin
        nvde += int'(vde);
        nvs  += int'(!vsync);
      end
    end
    chk("frame_period", second - first, 140);
    chk("vde_per_frame", nvde, 60);
    chk("vsync_low_per_frame", nvs, 28);

    // Underflow: 3-cycle FIFO gap at h=3, v=2
    found = 1'b0;
    for (int k = 0; k < 2 * FRAME && !found; k++) begin
      if (m_mode == M_RUN && m_pos == 2 * HMAX + 3) found = 1'b1;
      else step(1'b1, 1'b1, 1'b0, 8'h5A);
    end
    chk("uf_reached_position", found, 1);
    zeros = 0;
    repeat (3) begin
      step(1'b1, 1'b0, 1'b0, 8'h5A);
      if (vde && vid_data == 8'd0) zeros++;
    end
    repeat (20) begin
      step(1'b1, 1'b1, 1'b0, 8'h5A);
      if (vde && vid_data == 8'd0) zeros++;
    end
    chk("uf_zero_pixels", zeros, 3);
    chk("uf_flag_set", underflow, 1);
    repeat (30) step(1'b1, 1'b1, 1'b0, 8'h5A);
    chk("uf_flag_sticky", underflow, 1);
    step(1'b1, 1'b1, 1'b1, 8'h5A);
    chk("uf_flag_cleared", underflow, 0);

    // Graceful stop requested at v=3
    found = 1'b0;
    for (int k = 0; k < 2 * FRAME && !found; k++) begin
      if (m_mode == M_RUN && m_pos == 3 * HMAX) found = 1'b1;
      else step(1'b1, 1'b1, 1'b0, 8'h33);
    end
    chk("stop_reached_position", found, 1);
    found = 1'b0;
    for (int k = 0; k < 2 * FRAME && !found; k++) begin
      step(1'b0, 1'b1, 1'b0, 8'h33);
      if (!busy) found = 1'b1;
    end
    chk("stop_went_idle", found, 1);
    chk("stop_last_h", hdata, 13);
    chk("stop_last_v", vdata, 9);
    chk("stop_vsync_high", vsync, 1);
    rd_cnt = 0;
    repeat (20) step(1'b0, 1'b1, 1'b0, 8'h33);
    chk("stop_no_fifo_rd", rd_cnt, 0);

    // Asynchronous reset mid-line at h=5
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      if (m_mode == M_RUN && m_pos == 5) found = 1'b1;
      else step(1'b1, 1'b1, 1'b0, 8'h77);
    end
    chk("arst_reached_position", found, 1);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check_reset_values("arst");
    model_reset();
    repeat (2) step(1'b1, 1'b0, 1'b0, 8'h77);
    #1 rstn = 1'b1;
    cnt = 0;
    repeat (10) begin
      step(1'b1, 1'b0, 1'b0, 8'h77);
      cnt += int'(vde);
    end
    chk("arst_no_vde_without_valid", cnt, 0);
    chk("arst_armed_busy", busy, 1);

    // Randomized traffic against the model
    e_rand = 1'b1;
    for (int k = 0; k < 2500; k++) begin
      if ($urandom_range(0, 59) == 0) e_rand = !e_rand;
      step(e_rand, $urandom_range(0, 7) != 0, $urandom_range(0, 29) == 0,
           8'($urandom));
    end

`ifdef BAYER_TPG_EN
    // Test pattern: pixel (3,5) reads 3^5 and the FIFO is never popped
    step(1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    model_reset();
    @(posedge clk);
    #2 rstn = 1'b1;
    tpg = 1'b1;
    rd_cnt = 0;
    found = 1'b0;
    for (int k = 0; k < 2 * FRAME && !found; k++) begin
      step(1'b1, 1'b1, 1'b0, 8'hEE);
      if (vde && hdata == 3 && vdata == 5) begin
        found = 1'b1;
        chk("tpg_pixel_3_5", vid_data, 8'h06);
      end
    end
    chk("tpg_pixel_seen", found, 1);
    chk("tpg_no_fifo_rd", rd_cnt, 0);
    tpg = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
